ldbuf_tracker: RTL and testbench

- Load-buffer bookkeeping between the load unit issue side and the data-cache response side. Used by the 64-bit, 2-commit-port, 8-scoreboard-entry core configuration.
- Allocates an entry per issued load and records the scoreboard trans_id, byte offset, size and sign flag. The entry index is the cache request tag.
- On cache response, aligns and extends the data and emits a registered writeback result. Frees the entry.
- Flush marks in-flight entries so their late responses are dropped silently.

---
 rtl/config_pkg.sv | 11 +
 rtl/cva6_config_pkg.sv | 10 +
 rtl/ldbuf_pkg.sv | 31 +++
 rtl/ldbuf_data_align.sv | 34 +++
 rtl/ldbuf_tracker.sv | 168 ++++++++++++++++
 tb/tb_ldbuf_tracker.sv | 324 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/config_pkg.sv
// Core configuration record type.
// Only the fields the load-buffer tracker reads are carried here:
// the load-buffer depth and the scoreboard depth.
package config_pkg;

    typedef struct packed {
        int unsigned NrLoadBufEntries;
        int unsigned NrScoreboardEntries;
    } cva6_cfg_t;

endpackage

// File: rtl/cva6_config_pkg.sv
// Default core configuration.
// 64-bit core with 2 commit ports, 8 scoreboard entries and 2 load-buffer entries.
package cva6_config_pkg;

    localparam config_pkg::cva6_cfg_t cva6_cfg = '{
        NrLoadBufEntries:    2,
        NrScoreboardEntries: 8
    };

endpackage

// File: rtl/ldbuf_pkg.sv
// Shared types for the load-buffer tracker and the load unit's forwarding path.
//   ldbuf_size_e     : access size encoding (LB/LH/LW/LD = 1/2/4/8 bytes)
//   ldbuf_meta_t     : per-load extraction info (offset, size, sign flag)
//   ldbuf_is_aligned : true when an offset is naturally aligned to a size
// The full entry record is declared in the top, because its trans_id width
// depends on the core configuration.
package ldbuf_pkg;

    typedef enum logic [1:0] {
        LB = 2'd0,
        LH = 2'd1,
        LW = 2'd2,
        LD = 2'd3
    } ldbuf_size_e;

    typedef struct packed {
        logic [2:0]  offset;
        ldbuf_size_e size;
        logic        is_signed;
    } ldbuf_meta_t;

    function automatic logic ldbuf_is_aligned(input logic [2:0] offset, input ldbuf_size_e size);
        case (size)
            LB:      return 1'b1;
            LH:      return offset[0] == 1'b0;
            LW:      return offset[1:0] == 2'b00;
            default: return offset == 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ldbuf_data_align.sv
// Combinational load-data alignment and extension.
// Shifts the raw 64-bit cache word right by offset bytes, keeps the low
// 1/2/4/8 bytes and fills the upper bits by sign or zero extension.
// Ports:
//   i_data   : raw 64-bit aligned word from the cache
//   i_offset : byte offset of the access within the word
//   i_size   : access size
//   i_signed : 1 = sign-extend, 0 = zero-extend
//   o_data   : aligned, extended 64-bit result
module ldbuf_data_align
    import ldbuf_pkg::*;
(
    input  logic [63:0]  i_data,
    input  logic [2:0]   i_offset,
    input  ldbuf_size_e  i_size,
    input  logic         i_signed,
    output logic [63:0]  o_data
);

    logic [63:0] w_shifted;

    assign w_shifted = i_data >> {i_offset, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            LB:      o_data = {{56{i_signed & w_shifted[7]}},  w_shifted[7:0]};
            LH:      o_data = {{48{i_signed & w_shifted[15]}}, w_shifted[15:0]};
            LW:      o_data = {{32{i_signed & w_shifted[31]}}, w_shifted[31:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/ldbuf_tracker.sv
// Load-buffer bookkeeping between load issue and data-cache responses.
// Each issued load takes the lowest free entry; the entry index is the cache
// request tag. A response frees its entry and, unless the entry was flushed,
// produces a registered writeback result one cycle later.
// Ports:
//   clk_i, rst_ni                 : clock, asynchronous active-low reset
//   flush_i                       : pipeline flush, marks in-flight entries
//   alloc_valid_i / alloc_ready_o : load issue handshake
//   alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_signed_i : load info
//   alloc_idx_o                   : entry granted to the issuing load
//   rsp_valid_i, rsp_idx_i, rsp_data_i : cache response
//   result_valid_o, result_trans_id_o, result_data_o : writeback result
//   empty_o, full_o               : buffer occupancy status
module ldbuf_tracker
    import ldbuf_pkg::*;
#(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = cva6_config_pkg::cva6_cfg,
    parameter int NrEntries = int'(CVA6Cfg.NrLoadBufEntries),
    parameter int IdxW      = (NrEntries > 1) ? $clog2(NrEntries) : 1,
    parameter int TransIdW  = $clog2(CVA6Cfg.NrScoreboardEntries)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [TransIdW-1:0] alloc_trans_id_i,
    input  logic [2:0]          alloc_offset_i,
    input  logic [1:0]          alloc_size_i,
    input  logic                alloc_signed_i,
    output logic [IdxW-1:0]     alloc_idx_o,
    input  logic                rsp_valid_i,
    input  logic [IdxW-1:0]     rsp_idx_i,
    input  logic [63:0]         rsp_data_i,
    output logic                result_valid_o,
    output logic [TransIdW-1:0] result_trans_id_o,
    output logic [63:0]         result_data_o,
    output logic                empty_o,
    output logic                full_o
);

    typedef struct packed {
        logic                valid;
        logic                flushed;
        logic [TransIdW-1:0] trans_id;
        ldbuf_meta_t         meta;
    } ldbuf_entry_t;

    ldbuf_entry_t          r_entries [NrEntries];
    logic                  r_result_valid;
    logic [TransIdW-1:0]   r_result_trans_id;
    logic [63:0]           r_result_data;

    logic [NrEntries-1:0]  w_valid;
    logic [IdxW-1:0]       w_alloc_idx;
    logic                  w_alloc_fire;
    logic                  w_rsp_in_range;
    ldbuf_entry_t          w_rsp_entry;
    logic                  w_rsp_hit;
    logic                  w_rsp_emit;
    logic [63:0]           w_aligned;

    always_comb begin
        w_valid = '0;
        for (int i = 0; i < NrEntries; i++) begin
            w_valid[i] = r_entries[i].valid;
        end
    end

    // Scan downwards so the lowest free index is the last one written.
    always_comb begin
        w_alloc_idx = '0;
        for (int i = NrEntries - 1; i >= 0; i--) begin
            if (!w_valid[i]) begin
                w_alloc_idx = IdxW'(i);
            end
        end
    end

    assign full_o        = &w_valid;
    assign empty_o       = ~|w_valid;
    assign alloc_ready_o = !full_o && !flush_i;
    assign alloc_idx_o   = w_alloc_idx;
    assign w_alloc_fire  = alloc_valid_i && alloc_ready_o;

    // Guard the lookup so a tag beyond a non-power-of-two depth reads as idle.
    assign w_rsp_in_range = int'(rsp_idx_i) < NrEntries;

    always_comb begin
        w_rsp_entry = '0;
        if (w_rsp_in_range) begin
            w_rsp_entry = r_entries[rsp_idx_i];
        end
    end

    assign w_rsp_hit  = rsp_valid_i && w_rsp_entry.valid;
    assign w_rsp_emit = w_rsp_hit && !w_rsp_entry.flushed && !flush_i;

    ldbuf_data_align u_align (
        .i_data   (rsp_data_i),
        .i_offset (w_rsp_entry.meta.offset),
        .i_size   (w_rsp_entry.meta.size),
        .i_signed (w_rsp_entry.meta.is_signed),
        .o_data   (w_aligned)
    );

    // A flushed entry stays valid until its response frees it, so it still
    // occupies a slot. The allocated entry is always free, so the allocation
    // write never collides with the flush or free updates.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NrEntries; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NrEntries; i++) begin
                if (flush_i && r_entries[i].valid) begin
                    r_entries[i].flushed <= 1'b1;
                end
                if (w_rsp_hit && rsp_idx_i == IdxW'(i)) begin
                    r_entries[i].valid <= 1'b0;
                end
                if (w_alloc_fire && w_alloc_idx == IdxW'(i)) begin
                    r_entries[i] <= '{
                        valid:    1'b1,
                        flushed:  1'b0,
                        trans_id: alloc_trans_id_i,
                        meta:     '{offset:    alloc_offset_i,
                                    size:      ldbuf_size_e'(alloc_size_i),
                                    is_signed: alloc_signed_i}
                    };
                end
            end
        end
    end

    // Tag and data hold their last values while no result is presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result_valid    <= 1'b0;
            r_result_trans_id <= '0;
            r_result_data     <= '0;
        end else begin
            r_result_valid <= w_rsp_emit;
            if (w_rsp_emit) begin
                r_result_trans_id <= w_rsp_entry.trans_id;
                r_result_data     <= w_aligned;
            end
        end
    end

    assign result_valid_o    = r_result_valid;
    assign result_trans_id_o = r_result_trans_id;
    assign result_data_o     = r_result_data;

    // A response to an idle entry is tolerated and dropped; report it without
    // treating it as a hard error.
    a_rsp_to_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rsp_valid_i |-> w_rsp_entry.valid)
        else $warning("load-buffer response to idle entry ignored");

    a_misaligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_alloc_fire |-> ldbuf_is_aligned(alloc_offset_i, ldbuf_size_e'(alloc_size_i)));

    a_alloc_rsp_same_idx: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(w_alloc_fire && w_rsp_hit && rsp_idx_i == w_alloc_idx));

endmodule

// File: tb/tb_ldbuf_tracker.sv
// Self-checking bench for ldbuf_tracker (default configuration: 2 entries,
// 3-bit trans_id). Expected writeback results are queued when a response is
// driven and compared by a monitor when the result appears.
module tb_ldbuf_tracker;

    localparam int IdxW     = 1;
    localparam int TransIdW = 3;

    logic                clk = 1'b0;
    logic                rstN;
    logic                flush;
    logic                allocValid;
    logic                allocReady;
    logic [TransIdW-1:0] allocTransId;
    logic [2:0]          allocOffset;
    logic [1:0]          allocSize;
    logic                allocSigned;
    logic [IdxW-1:0]     allocIdx;
    logic                rspValid;
    logic [IdxW-1:0]     rspIdx;
    logic [63:0]         rspData;
    logic                resultValid;
    logic [TransIdW-1:0] resultTransId;
    logic [63:0]         resultData;
    logic                empty;
    logic                full;

    int nChecks = 0;
    int nErrors = 0;
    int cycleCount = 0;

    typedef struct {
        logic [TransIdW-1:0] transId;
        logic [63:0]         data;
        int                  due;
    } expItem_t;

    expItem_t expQ[$];

    typedef struct {
        logic [TransIdW-1:0] transId;
        logic [2:0]          offset;
        logic [1:0]          size;
        logic                sgn;
        logic [63:0]         rawData;
        logic [63:0]         expData;
    } vector_t;

    vector_t vectors[9];

    logic [TransIdW-1:0] mTid  [2];
    logic [2:0]          mOff  [2];
    logic [1:0]          mSize [2];
    logic                mSgn  [2];

    ldbuf_tracker dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .flush_i           (flush),
        .alloc_valid_i     (allocValid),
        .alloc_ready_o     (allocReady),
        .alloc_trans_id_i  (allocTransId),
        .alloc_offset_i    (allocOffset),
        .alloc_size_i      (allocSize),
        .alloc_signed_i    (allocSigned),
        .alloc_idx_o       (allocIdx),
        .rsp_valid_i       (rspValid),
        .rsp_idx_i         (rspIdx),
        .rsp_data_i        (rspData),
        .result_valid_o    (resultValid),
        .result_trans_id_o (resultTransId),
        .result_data_o     (resultData),
        .empty_o           (empty),
        .full_o            (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Byte-mask formulation of the load extraction.
    function automatic logic [63:0] modelAlign(input logic [63:0] d, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
        logic [63:0] shifted;
        logic [63:0] mask;
        int          bits;
        shifted = d >> (int'(off) * 8);
        bits    = 8 << size;
        mask    = (bits == 64) ? '1 : ((64'd1 << bits) - 64'd1);
        if (sgn && shifted[bits-1]) return shifted | ~mask;
        return shifted & mask;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleInputs();
        flush        = 1'b0;
        allocValid   = 1'b0;
        allocTransId = '0;
        allocOffset  = '0;
        allocSize    = '0;
        allocSigned  = 1'b0;
        rspValid     = 1'b0;
        rspIdx       = '0;
        rspData      = '0;
    endtask

    task automatic setAlloc(input logic [2:0] tid, input logic [2:0] off, input logic [1:0] size, input logic sgn);
        allocValid   = 1'b1;
        allocTransId = tid;
        allocOffset  = off;
        allocSize    = size;
        allocSigned  = sgn;
    endtask

    task automatic recordAlloc(input int idx);
        mTid[idx]  = allocTransId;
        mOff[idx]  = allocOffset;
        mSize[idx] = allocSize;
        mSgn[idx]  = allocSigned;
    endtask

    task automatic allocOne(input logic [2:0] tid, input logic [2:0] off, input logic [1:0] size,
                            input logic sgn, input int expIdx);
        setAlloc(tid, off, size, sgn);
        #1;
        checkOutput("alloc_ready", allocReady, 1'b1);
        checkOutput("alloc_idx", allocIdx, expIdx);
        recordAlloc(expIdx);
        step();
        allocValid = 1'b0;
    endtask

    task automatic setRsp(input int idx, input logic [63:0] data, input bit expectResult);
        rspValid = 1'b1;
        rspIdx   = IdxW'(idx);
        rspData  = data;
        if (expectResult)
            expQ.push_back('{mTid[idx], modelAlign(data, mOff[idx], mSize[idx], mSgn[idx]), cycleCount + 1});
    endtask

    task automatic respondOne(input int idx, input logic [63:0] data, input bit expectResult);
        setRsp(idx, data, expectResult);
        step();
        rspValid = 1'b0;
    endtask

    // One table vector: allocate into an empty buffer, then respond.
    task automatic applyStimulus(input vector_t v);
        setAlloc(v.transId, v.offset, v.size, v.sgn);
        #1;
        checkOutput("vec_alloc_idx", allocIdx, 0);
        step();
        allocValid = 1'b0;
        rspValid   = 1'b1;
        rspIdx     = '0;
        rspData    = v.rawData;
        expQ.push_back('{v.transId, v.expData, cycleCount + 1});
        step();
        rspValid = 1'b0;
    endtask

    // Result monitor: a result must appear exactly in the cycle it is due.
    always @(negedge clk) begin
        logic expValid;
        if (rstN === 1'b1) begin
            expValid = (expQ.size() > 0) && (expQ[0].due == cycleCount);
            checkOutput("result_valid", resultValid, expValid);
            if (expValid) begin
                if (resultValid) begin
                    checkOutput("result_trans_id", resultTransId, expQ[0].transId);
                    checkOutput("result_data", resultData, expQ[0].data);
                end
                void'(expQ.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors[0] = '{3'd5, 3'd4, 2'd2, 1'b1, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001};
        vectors[1] = '{3'd3, 3'd7, 2'd0, 1'b0, 64'hAB00_0000_0000_0000, 64'h0000_0000_0000_00AB};
        vectors[2] = '{3'd3, 3'd7, 2'd0, 1'b1, 64'hAB00_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFAB};
        vectors[3] = '{3'd1, 3'd0, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
        vectors[4] = '{3'd2, 3'd2, 2'd1, 1'b1, 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765};
        vectors[5] = '{3'd6, 3'd6, 2'd1, 1'b0, 64'hF00D_0000_0000_0000, 64'h0000_0000_0000_F00D};
        vectors[6] = '{3'd7, 3'd0, 2'd2, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
        vectors[7] = '{3'd0, 3'd3, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
        vectors[8] = '{3'd4, 3'd0, 2'd3, 1'b1, 64'hFFFF_0000_0000_0001, 64'hFFFF_0000_0000_0001};

        rstN = 1'b1;
        idleInputs();
        #1 rstN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_result_valid", resultValid, 1'b0);
        checkOutput("reset_result_tid", resultTransId, 0);
        checkOutput("reset_result_data", resultData, 64'h0);
        checkOutput("reset_empty", empty, 1'b1);
        checkOutput("reset_full", full, 1'b0);
        rstN = 1'b1;
        #1;
        checkOutput("idle_ready", allocReady, 1'b1);
        checkOutput("idle_idx", allocIdx, 0);
        step();

        $display("[TB] table vectors");
        for (int i = 0; i < 9; i++) applyStimulus(vectors[i]);
        step();

        $display("[TB] fill and out-of-order responses");
        allocOne(3'd1, 3'd0, 2'd3, 1'b0, 0);
        allocOne(3'd2, 3'd0, 2'd3, 1'b0, 1);
        #1;
        checkOutput("fill_full", full, 1'b1);
        checkOutput("fill_empty", empty, 1'b0);
        setAlloc(3'd4, 3'd0, 2'd3, 1'b0);
        setRsp(1, 64'h2222_0000_1111_0002, 1'b1);
        #1;
        checkOutput("ready_in_free_cycle", allocReady, 1'b0);
        step();
        checkOutput("ready_after_free", allocReady, 1'b1);
        checkOutput("regrant_idx", allocIdx, 1);
        recordAlloc(1);
        setRsp(0, 64'h1111_0000_2222_0001, 1'b1);
        step();
        allocValid = 1'b0;
        rspValid   = 1'b0;
        respondOne(1, 64'h4444_3333_2222_1111, 1'b1);
        #1;
        checkOutput("ooo_empty", empty, 1'b1);
        step();

        $display("[TB] flush with two entries in flight");
        allocOne(3'd2, 3'd0, 2'd3, 1'b1, 0);
        allocOne(3'd3, 3'd4, 2'd2, 1'b0, 1);
        flush = 1'b1;
        setAlloc(3'd5, 3'd0, 2'd3, 1'b0);
        #1;
        checkOutput("flush_ready", allocReady, 1'b0);
        checkOutput("flush_full", full, 1'b1);
        step();
        flush      = 1'b0;
        allocValid = 1'b0;
        #1;
        checkOutput("post_flush_full", full, 1'b1);
        respondOne(0, 64'hDEAD_BEEF_0000_0001, 1'b0);
        #1;
        checkOutput("flush_mid_empty", empty, 1'b0);
        checkOutput("flush_mid_full", full, 1'b0);
        respondOne(1, 64'hCAFE_0000_0000_0002, 1'b0);
        #1;
        checkOutput("flush_done_empty", empty, 1'b1);

        $display("[TB] flush in the response cycle");
        allocOne(3'd6, 3'd0, 2'd3, 1'b0, 0);
        flush = 1'b1;
        setRsp(0, 64'h0000_0000_0000_0066, 1'b0);
        step();
        flush    = 1'b0;
        rspValid = 1'b0;
        #1;
        checkOutput("flush_rsp_empty", empty, 1'b1);

        $display("[TB] normal load after flush");
        allocOne(3'd7, 3'd1, 2'd0, 1'b1, 0);
        respondOne(0, 64'h0000_0000_0000_7F00, 1'b1);
        step();

        $display("[TB] spurious responses");
        respondOne(1, 64'h1234_5678_9ABC_DEF0, 1'b0);
        #1;
        checkOutput("spur_empty", empty, 1'b1);
        checkOutput("spur_idx", allocIdx, 0);
        allocOne(3'd1, 3'd0, 2'd1, 1'b0, 0);
        respondOne(1, 64'h0000_0000_0000_5555, 1'b0);
        #1;
        checkOutput("spur_keep_empty", empty, 1'b0);
        checkOutput("spur_keep_idx", allocIdx, 1);
        respondOne(0, 64'h0000_0000_0000_A5A5, 1'b1);
        step();

        $display("[TB] asynchronous reset mid-flight");
        allocOne(3'd3, 3'd0, 2'd3, 1'b0, 0);
        allocOne(3'd4, 3'd0, 2'd3, 1'b0, 1);
        respondOne(0, 64'h0BAD_F00D_0000_0003, 1'b1);
        #2 rstN = 1'b0;
        #1;
        checkOutput("areset_result_valid", resultValid, 1'b0);
        checkOutput("areset_result_tid", resultTransId, 0);
        checkOutput("areset_result_data", resultData, 64'h0);
        checkOutput("areset_empty", empty, 1'b1);
        checkOutput("areset_full", full, 1'b0);
        checkOutput("areset_idx", allocIdx, 0);
        @(negedge clk);
        rstN = 1'b1;
        respondOne(1, 64'h0000_0000_0000_0004, 1'b0);
        #1;
        checkOutput("after_reset_empty", empty, 1'b1);
        step();
        step();

        checkOutput("queue_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
